pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline clock-enable and debug controller for the MIPS core top level. It replaces the fixed divide-by-two pipeline clock with a single-clock-domain enable pulse whose ratio is programmable. It adds run/halt/single-step control with a PC breakpoint, and a registered multi-channel debug read port for registers, memory and other observables. All pipeline stages run on `clock` and advance only when `pipe_en` is high.

## Interface
- `DIV_WIDTH`, 8: width of the divide-ratio input and internal counter.
- `DATA_WIDTH`, 32: width of each debug channel and of the PC.
- `ADDR_WIDTH`, 5: debug address width, broadcast to all channels.
- `NUM_CH`, 4: number of debug channels (≥1). `SEL_WIDTH` = max(1, clog2(NUM_CH)).
- `RESET_RUN`, 1: 1 = RUN after reset, 0 = HALT after reset.

- `clock`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-low.
- `div_ratio`  in  DIV_WIDTH  one `pipe_en` pulse every `div_ratio`+1 clocks.
- `run_req`  in  1  pulse: enter RUN.
- `halt_req`  in  1  pulse: enter HALT.
- `step_req`  in  1  pulse: issue exactly one `pipe_en`, then HALT.
- `bp_en`  in  1  breakpoint enable.
- `bp_pc`  in  DATA_WIDTH  breakpoint address.
- `pc_in`  in  DATA_WIDTH  current fetch PC from the fetch stage.
- `pipe_en`  out  1  pipeline advance enable, one-cycle pulse.
- `halted`  out  1  high in HALT.
- `bp_hit`  out  1  sticky; set by breakpoint halt, cleared by `run_req` or `step_req`.
- `cycle_count`  out  32  number of `pipe_en` pulses issued; wraps.
- `dbg_sel`  in  SEL_WIDTH  debug channel select.
- `dbg_addr`  in  ADDR_WIDTH  debug address.
- `ch_addr`  out  ADDR_WIDTH  combinational copy of `dbg_addr` to the channels.
- `ch_data`  in  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `dbg_data`  out  DATA_WIDTH  registered selected channel data.

## Operation
- **States:** RUN, HALT, STEP.
- **Request priority:** `halt_req` > `step_req` > `run_req`.
- **RUN**
  - The divider counter `cnt` increments each clock.
  - When `cnt` ≥ `div_ratio`, the next cycle has `pipe_en`=1, `cnt` is set to 0 and `cycle_count` increments.
- **HALT**
  - `cnt` is held at 0 and `pipe_en`=0.
  - `step_req` goes to STEP. `run_req` goes to RUN.
- **STEP**
  - Counts exactly as RUN.
  - The first `pipe_en` pulse issued returns the FSM to HALT.
- **Breakpoint:** when a `pipe_en` pulse is issued while `bp_en`=1 and `pc_in`==`bp_pc`:
  - the FSM goes to HALT after that pulse;
  - `bp_hit` sets.
  - The matching instruction is therefore fetched, and no further pulse follows.
- **Requests in other states:**
  - `halt_req` in RUN or STEP goes to HALT next cycle. If a pulse is due in that same cycle, it is suppressed.
  - `run_req` in RUN and `step_req` in STEP are ignored.
- **Divide ratio:**
  - `div_ratio`=0 gives `pipe_en` every cycle.
  - `div_ratio`=1 reproduces the legacy divide-by-two rate.
  - A lowered `div_ratio` with `cnt` above it produces a pulse on the next cycle.
- **Debug read port:**
  - Each clock, `dbg_data` ← channel `dbg_sel`.
  - `dbg_sel` ≥ `NUM_CH` yields 0.
  - The port operates in every state and is independent of `pipe_en`.

## Timing
- **Reset values:**
  - `pipe_en`=0, `cnt`=0, `cycle_count`=0, `bp_hit`=0, `dbg_data`=0.
  - State is RUN if `RESET_RUN`, else HALT; `halted` matches the state.
- **First pulse after reset release in RUN:** `div_ratio`+1 clocks after the first rising edge.
- **Request latency:** `run_req`, `halt_req` and `step_req` are sampled on a rising edge and take effect on that edge; `halted` updates in the same edge.
- **Step from HALT:** `step_req` at edge t gives `pipe_en` high during cycle t+`div_ratio`+1.
- **Debug read latency:** `dbg_data` is valid one clock after `dbg_sel`/`dbg_addr`/`ch_data`, which must be stable before that edge.
- **Reset mid-operation:** asserting `reset` during any state clears everything immediately and asynchronously; an in-flight STEP is abandoned.

## Structure
- **Shared header (`mips_defs`):** state encodings `ST_RUN`, `ST_HALT`, `ST_STEP` (2 bits) and the `cycle_count` width constant.
- **Sub-module `clk_en_divider`:**
  - Contains the counter, the ≥ compare and the pulse register.
  - Inputs: `clear`, `count_en`. Output: `tick`.
  - Reused for peripheral timers.
- **In `pipe_ctrl`:** the FSM, breakpoint compare and debug mux.

## Test plan
- Reset with `RESET_RUN`=1, `div_ratio`=3 → `pipe_en` high on cycles 4, 8, 12; `cycle_count`=3 after cycle 12.
- `div_ratio`=0 in RUN for 10 cycles → `pipe_en` constantly 1 and `cycle_count`=10; then `halt_req` → `pipe_en` 0 from the next cycle and `halted`=1.
- In HALT with `div_ratio`=2, pulse `step_req` → exactly one `pipe_en` 3 cycles later, then HALT; `cycle_count` +1. A second `step_req` gives one more pulse.
- `bp_en`=1, `bp_pc`=0x40, `pc_in` stepping 0x38, 0x3C, 0x40 per pulse → HALT after the 0x40 pulse with `bp_hit`=1. `run_req` clears `bp_hit` and resumes.
- `NUM_CH`=4, `ch_data` channel 2 = 0xDEADBEEF, `dbg_sel`=2 → `dbg_data`=0xDEADBEEF one cycle later. With `NUM_CH`=3 and `dbg_sel`=3 → 0.
- Assert `reset` mid-STEP and mid-count with `cycle_count`=0xFFFFFFFF → all outputs return to reset values immediately. A separate run from 0xFFFFFFFF wraps `cycle_count` to 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS core top level: pipeline control state
// encodings and the width of the pipeline advance counter.
package mips_defs;

    localparam int CYCLE_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/clk_en_divider.sv
// Programmable clock-enable divider: one registered tick every div_ratio+1
// counted clocks. Also used for peripheral timers.
module clk_en_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 count_en,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    output logic                 tick,
    output logic                 fire
);

    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic                 tick_reg;

    // ">=" rather than "==" so a ratio lowered below the running count
    // still produces a pulse on the next edge instead of wrapping.
    always_comb begin
        fire     = !clear && count_en && (cnt_reg >= div_ratio);
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (count_en) begin
            cnt_next = fire ? '0 : cnt_reg + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            tick_reg <= fire;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline clock-enable and debug controller: run/halt/single-step FSM with
// PC breakpoint, pulse counter and a registered multi-channel debug read port.
module pipe_ctrl
    import mips_defs::*;
#(
    parameter int DIV_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CH     = 4,
    parameter bit RESET_RUN  = 1'b1,
    localparam int SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DIV_WIDTH-1:0]         div_ratio,
    input  logic                         run_req,
    input  logic                         halt_req,
    input  logic                         step_req,
    input  logic                         bp_en,
    input  logic [DATA_WIDTH-1:0]        bp_pc,
    input  logic [DATA_WIDTH-1:0]        pc_in,
    output logic                         pipe_en,
    output logic                         halted,
    output logic                         bp_hit,
    output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count,
    input  logic [SEL_WIDTH-1:0]         dbg_sel,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [ADDR_WIDTH-1:0]        ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    pipe_state_t                  state_reg;
    pipe_state_t                  state_next;
    logic                         bp_hit_reg;
    logic                         bp_hit_next;
    logic [CYCLE_COUNT_WIDTH-1:0] cycle_count_reg;
    logic [DATA_WIDTH-1:0]        dbg_data_reg;
    logic [DATA_WIDTH-1:0]        dbg_data_next;
    logic                         div_clear;
    logic                         div_count_en;
    logic                         div_fire;
    logic                         bp_stop;
    logic [DATA_WIDTH-1:0]        ch_word [NUM_CH];

    // The pipeline is advancing through pc_in during a pulse cycle, so a
    // match here means the breakpoint instruction has just been fetched.
    assign bp_stop = pipe_en && bp_en && (pc_in == bp_pc);

    always_comb begin
        state_next  = state_reg;
        bp_hit_next = bp_hit_reg;
        unique case (state_reg)
            ST_RUN: begin
                if (halt_req || bp_stop) state_next = ST_HALT;
                else if (step_req)       state_next = ST_STEP;
            end
            ST_STEP: begin
                if (halt_req || pipe_en) state_next = ST_HALT;
                else if (run_req)        state_next = ST_RUN;
            end
            ST_HALT: begin
                if (step_req)            state_next = ST_STEP;
                else if (run_req)        state_next = ST_RUN;
            end
            default:                     state_next = ST_HALT;
        endcase
        if (bp_stop)                     bp_hit_next = 1'b1;
        else if (run_req || step_req)    bp_hit_next = 1'b0;
    end

    // Counting starts on the edge after leaving HALT; entering HALT clears
    // the divider on the same edge, which also drops any pulse due then.
    assign div_count_en = (state_reg != ST_HALT);
    assign div_clear    = (state_next == ST_HALT);

    clk_en_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .clock     (clock),
        .reset     (reset),
        .clear     (div_clear),
        .count_en  (div_count_en),
        .div_ratio (div_ratio),
        .tick      (pipe_en),
        .fire      (div_fire)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_word[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        dbg_data_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dbg_sel == SEL_WIDTH'(k)) dbg_data_next = ch_word[k];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= RESET_RUN ? ST_RUN : ST_HALT;
            bp_hit_reg      <= 1'b0;
            cycle_count_reg <= '0;
            dbg_data_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            bp_hit_reg      <= bp_hit_next;
            dbg_data_reg    <= dbg_data_next;
            if (div_fire) cycle_count_reg <= cycle_count_reg + CYCLE_COUNT_WIDTH'(1);
        end
    end

    assign halted      = (state_reg == ST_HALT);
    assign bp_hit      = bp_hit_reg;
    assign cycle_count = cycle_count_reg;
    assign ch_addr     = dbg_addr;
    assign dbg_data    = dbg_data_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: divider timing, halt/step/breakpoint control,
// debug read port on 4- and 3-channel instances, and asynchronous reset.
module tb_pipe_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   div_ratio;
    logic         run_req, halt_req, step_req, bp_en;
    logic [31:0]  bp_pc, pc_in;
    logic [1:0]   dbg_sel;
    logic [4:0]   dbg_addr;
    logic [127:0] ch_data;

    logic         pipe_en, halted, bp_hit;
    logic [31:0]  cycle_count, dbg_data;
    logic [4:0]   ch_addr;

    logic         pipe_en3, halted3, bp_hit3;
    logic [31:0]  cycle_count3, dbg_data3;
    logic [4:0]   ch_addr3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_ctrl #(.NUM_CH(4), .RESET_RUN(1'b1)) u_dut (
        .clock(clock), .reset(reset), .div_ratio(div_ratio),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_pc(bp_pc), .pc_in(pc_in),
        .pipe_en(pipe_en), .halted(halted), .bp_hit(bp_hit),
        .cycle_count(cycle_count), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr),
        .ch_addr(ch_addr), .ch_data(ch_data), .dbg_data(dbg_data)
    );

    pipe_ctrl #(.NUM_CH(3), .RESET_RUN(1'b0)) u_dut3 (
        .clock(clock), .reset(reset), .div_ratio(div_ratio),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_pc(bp_pc), .pc_in(pc_in),
        .pipe_en(pipe_en3), .halted(halted3), .bp_hit(bp_hit3),
        .cycle_count(cycle_count3), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr),
        .ch_addr(ch_addr3), .ch_data(ch_data[95:0]), .dbg_data(dbg_data3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        div_ratio = 8'd3;
        run_req   = 1'b0;
        halt_req  = 1'b0;
        step_req  = 1'b0;
        bp_en     = 1'b0;
        bp_pc     = 32'h0;
        pc_in     = 32'h0;
        dbg_sel   = 2'd0;
        dbg_addr  = 5'h0A;
        ch_data   = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

        #22;
        $display("reset: checking reset values");
        check_val("rst_pipe_en",  32'(pipe_en), 32'd0);
        check_val("rst_halted",   32'(halted), 32'd0);
        check_val("rst_halted3",  32'(halted3), 32'd1);
        check_val("rst_bp_hit",   32'(bp_hit), 32'd0);
        check_val("rst_cycles",   cycle_count, 32'd0);
        check_val("rst_dbg_data", dbg_data, 32'd0);
        reset = 1'b1;

        $display("run: div_ratio=3 for 13 edges");
        for (int n = 1; n <= 13; n++) begin
            next_edge();
            check_val($sformatf("div3_pe_e%0d", n), 32'(pipe_en), 32'(n % 4 == 0));
        end
        check_val("div3_cycles",  cycle_count, 32'd3);
        check_val("div3_halted",  32'(halted), 32'd0);
        check_val("halted3_idle", 32'(halted3), 32'd1);
        check_val("ch_addr_copy", 32'(ch_addr), 32'h0A);
        check_val("dbg_sel0",     dbg_data, 32'h1111_1111);

        $display("run: div_ratio=0 for 10 edges then halt");
        div_ratio = 8'd0;
        for (int n = 0; n < 10; n++) begin
            next_edge();
            check_val($sformatf("div0_pe_%0d", n), 32'(pipe_en), 32'd1);
        end
        check_val("div0_cycles", cycle_count, 32'd13);
        halt_req = 1'b1;
        next_edge();
        halt_req = 1'b0;
        check_val("halt_pe",     32'(pipe_en), 32'd0);
        check_val("halt_halted", 32'(halted), 32'd1);
        check_val("halt_cycles", cycle_count, 32'd13);
        next_edge();
        check_val("halt_idle_pe", 32'(pipe_en), 32'd0);

        div_ratio = 8'd2;
        for (int s = 0; s < 2; s++) begin
            $display("step: request %0d with div_ratio=2", s);
            step_req = 1'b1;
            for (int i = 0; i < 5; i++) begin
                next_edge();
                step_req = 1'b0;
                check_val($sformatf("step%0d_pe_%0d", s, i), 32'(pipe_en), 32'(i == 3));
                check_val($sformatf("step%0d_halted_%0d", s, i), 32'(halted), 32'(i == 4));
            end
            check_val($sformatf("step%0d_cycles", s), cycle_count, 32'(14 + s));
        end

        $display("breakpoint: bp_pc=0x40, pc from 0x38, div_ratio=1");
        div_ratio = 8'd1;
        pc_in     = 32'h38;
        bp_pc     = 32'h40;
        bp_en     = 1'b1;
        run_req   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_edge();
            run_req = 1'b0;
            check_val($sformatf("bp_pe_%0d", i), 32'(pipe_en), 32'(i == 2 || i == 4 || i == 6));
            check_val($sformatf("bp_halted_%0d", i), 32'(halted), 32'(i >= 7));
            check_val($sformatf("bp_hit_%0d", i), 32'(bp_hit), 32'(i >= 7));
            if (i == 3 || i == 5 || i == 7) pc_in = pc_in + 32'd4;
        end
        check_val("bp_cycles", cycle_count, 32'd18);

        $display("resume: run_req after breakpoint");
        run_req = 1'b1;
        next_edge();
        run_req = 1'b0;
        check_val("resume_bp_hit", 32'(bp_hit), 32'd0);
        check_val("resume_halted", 32'(halted), 32'd0);
        next_edge();
        check_val("resume_pe_0", 32'(pipe_en), 32'd0);
        next_edge();
        check_val("resume_pe_1", 32'(pipe_en), 32'd1);
        halt_req = 1'b1;
        next_edge();
        halt_req = 1'b0;
        check_val("resume_halt",   32'(halted), 32'd1);
        check_val("resume_cycles", cycle_count, 32'd19);

        $display("debug: channel reads");
        dbg_sel = 2'd2;
        check_val("dbg_latency", dbg_data, 32'h1111_1111);
        next_edge();
        check_val("dbg_sel2",   dbg_data, 32'hDEAD_BEEF);
        check_val("dbg3_sel2",  dbg_data3, 32'hDEAD_BEEF);
        dbg_sel = 2'd3;
        next_edge();
        check_val("dbg_sel3",   dbg_data, 32'h4444_4444);
        check_val("dbg3_sel3",  dbg_data3, 32'h0);
        dbg_addr = 5'h1F;
        #1;
        check_val("ch_addr_1f", 32'(ch_addr), 32'h1F);

        $display("reset: asynchronous reset during STEP");
        div_ratio = 8'd5;
        step_req  = 1'b1;
        next_edge();
        step_req  = 1'b0;
        next_edge();
        next_edge();
        check_val("midstep_halted", 32'(halted), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check_val("arst_pipe_en",  32'(pipe_en), 32'd0);
        check_val("arst_halted",   32'(halted), 32'd0);
        check_val("arst_halted3",  32'(halted3), 32'd1);
        check_val("arst_cycles",   cycle_count, 32'd0);
        check_val("arst_bp_hit",   32'(bp_hit), 32'd0);
        check_val("arst_dbg_data", dbg_data, 32'd0);
        reset     = 1'b1;
        div_ratio = 8'd0;
        next_edge();
        check_val("post_rst_pe",     32'(pipe_en), 32'd1);
        check_val("post_rst_cycles", cycle_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
